fmap_writeback: RTL and testbench
=================================

// Module: fmap_writeback
// PURPOSE
//   Write-side counterpart of the feature-map BRAM read path. Takes the PE's
//   signed 16-bit result stream and requantises each result to int8 (arithmetic
//   shift, optional ReLU, saturation). Packs 8 results per 64-bit word and
//   writes word pairs into the dual-port feature BRAM (BRAM32k/BRAM4k) using
//   both ports per cycle. It sits between the PE array output and the BRAM
//   write ports of the next layer's input buffer.
// PARAMETERS
//   IN_W   16  width of signed PE result
//   DW     64  BRAM word width; 8 int8 lanes, lane0 = bits[7:0]
//   AW     12  BRAM address width; addresses wrap modulo 2**AW
//   LEN_W  15  width of the byte-count field
// PORTS
//   clk        in   1      system clock
//   rst        in   1      asynchronous reset, active high
//   start      in   1      one-cycle pulse; latches base_addr/len/shift/relu_en
//   base_addr  in   AW     first word address written
//   len        in   LEN_W  number of results (bytes) in the job; 0 = empty job
//   shift      in   4      arithmetic right-shift amount for requantisation
//   relu_en    in   1      1: negative results forced to 0 before saturation
//   in_data    in   IN_W   signed PE result
//   in_valid   in   1      in_data valid
//   in_ready   out  1      block accepts in_data this cycle
//   addr_a     out  AW     port A word address
//   din_a      out  DW     port A write data
//   we_a       out  1      port A write enable
//   addr_b     out  AW     port B word address
//   din_b      out  DW     port B write data
//   we_b       out  1      port B write enable
//   busy       out  1      job in progress (start..done inclusive)
//   done       out  1      one-cycle pulse: last write of the job has issued
// BEHAVIOUR
//   Reset: state IDLE; in_ready, we_a, we_b, busy, done = 0; addr_*, din_* = 0;
//     all counters and pack buffers cleared. Reset mid-job abandons the job
//     with no further writes.
//   FSM IDLE -> RUN on start (len != 0); IDLE -> DONE on start with len == 0.
//     RUN -> FLUSH when the final byte is accepted; FLUSH -> DONE after the
//     final write cycle; DONE -> IDLE after one cycle (done = 1 in DONE).
//     start is ignored unless IDLE. busy = (state != IDLE).
//   in_ready = (state == RUN). Handshake: byte accepted when in_valid & in_ready.
//     There is no back-pressure inside a job; a stall only occurs while in_valid = 0.
//   Requant per accepted value: t = in_data >>> shift (sign-preserving);
//     if relu_en & t < 0 then t = 0; byte = clamp(t, -128, 127), two's complement.
//   Packing: the k-th accepted byte of a word goes to lane k (bits 8k+7:8k).
//     Words alternate between slot0 and slot1. Completing slot1 registers the
//     pair on the next edge: we_a = we_b = 1 for one cycle;
//     addr_a = ptr, din_a = slot0; addr_b = ptr+1, din_b = slot1; ptr += 2.
//     Packing continues into cleared slots in the same cycle, so one byte per
//     cycle is sustained.
//   Final byte accepted at cycle t (FLUSH): the write at t+1 flushes all
//     remaining data. The unfilled lanes of a partial word are zero.
//     If only slot0 holds data, only we_a = 1 (we_b = 0).
//     If slot1 holds data, both ports are written. If the final byte completed
//     a pair, that pair is the flush write. done = 1 at t+2.
//   Address arithmetic is modulo 2**AW (ptr+1 from 4095 is 0). we_* are
//     registered; addr_*/din_* hold their last value when we_* = 0.
// TESTING
//   1 len=16, base=0x010, shift=0, relu=0, in=0..15 back-to-back
//     -> a single cycle with we_a=we_b=1: addr_a=0x010, din_a=0x0706050403020100;
//     addr_b=0x011, din_b=0x0F0E0D0C0B0A0908. done 2 cycles after the last byte.
//   2 len=3, in=1,2,3 -> one write: we_a=1, we_b=0, addr_a=base,
//     din_a=0x0000000000030201; then a done pulse.
//   3 saturation: shift=2, relu=0, in=0x7FFF,0x8000,-4 -> bytes 0x7F,0x80,0xFF;
//     with relu=1 -> 0x7F,0x00,0x00.
//   4 wrap: base=0xFFF, len=24 -> writes to 0xFFF/0x000, then 0x001 port A only.
//   5 len=0 start -> done one cycle later; no we_*. start pulsed while busy -> ignored.
//   6 rst asserted after 10 of 16 bytes -> no writes; outputs 0; a new job
//     then behaves as in scenario 1. Random in_valid gaps give the same memory image.

Source files
------------

// File: rtl/fmap_writeback.sv
// fmap_writeback: requantise signed PE results to int8, pack 8 per word, write word pairs to dual-port BRAM
module fmap_writeback #(
  parameter int IN_W  = 16,
  parameter int DW    = 64,
  parameter int AW    = 12,
  parameter int LEN_W = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [3:0]       shift,
  input  logic             relu_en,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [AW-1:0]    addr_a,
  output logic [DW-1:0]    din_a,
  output logic             we_a,
  output logic [AW-1:0]    addr_b,
  output logic [DW-1:0]    din_b,
  output logic             we_b,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  localparam logic signed [IN_W-1:0] q_max = IN_W'(127);
  localparam logic signed [IN_W-1:0] q_min = -IN_W'(128);
  state_t state, state_nx;
  logic [LEN_W-1:0] cnt;
  logic [AW-1:0] ptr;
  logic [2:0] lane;
  logic sel, relu_r, acc, last;
  logic [3:0] shift_r;
  logic [DW-1:0] slot0, slot1, s0_new, s1_new, lane_v;
  logic signed [IN_W-1:0] t, t_r;
  logic [7:0] q;
  assign in_ready = state == RUN;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign acc = in_valid && state == RUN;
  assign last = acc && cnt == LEN_W'(1);
  always_comb begin
    t = $signed(in_data) >>> shift_r;
    t_r = (relu_r && t < 0) ? '0 : t;
    q = (t_r > q_max) ? 8'h7f : (t_r < q_min) ? 8'h80 : t_r[7:0];
    lane_v = DW'(q) << {lane, 3'b000};
    s0_new = sel ? slot0 : slot0 | lane_v;
    s1_new = sel ? slot1 | lane_v : slot1;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (len == '0) ? DONE : RUN;
      RUN:     if (last) state_nx = FLUSH;
      FLUSH:   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      lane <= '0;
      sel <= 1'b0;
      slot0 <= '0;
      slot1 <= '0;
      shift_r <= '0;
      relu_r <= 1'b0;
      addr_a <= '0;
      din_a <= '0;
      we_a <= 1'b0;
      addr_b <= '0;
      din_b <= '0;
      we_b <= 1'b0;
    end else begin
      state <= state_nx;
      we_a <= 1'b0;
      we_b <= 1'b0;
      if (state == IDLE && start) begin
        ptr <= base_addr;
        cnt <= len;
        shift_r <= shift;
        relu_r <= relu_en;
        lane <= '0;
        sel <= 1'b0;
        slot0 <= '0;
        slot1 <= '0;
      end
      if (acc) begin
        cnt <= cnt - LEN_W'(1);
        // a completed pair or the job's final byte drains both slots in one write
        if (last || (sel && lane == 3'd7)) begin
          we_a <= 1'b1;
          addr_a <= ptr;
          din_a <= s0_new;
          we_b <= sel;
          if (sel) begin
            addr_b <= ptr + AW'(1);
            din_b <= s1_new;
          end
          ptr <= ptr + AW'(2);
          slot0 <= '0;
          slot1 <= '0;
          sel <= 1'b0;
          lane <= '0;
        end else begin
          slot0 <= s0_new;
          slot1 <= s1_new;
          lane <= lane + 3'd1;
          if (lane == 3'd7) sel <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fmap_writeback.sv
// tb_fmap_writeback: drives requant/pack jobs and checks BRAM writes against a byte-level reference model
module tb_fmap_writeback;
  logic clk = 0, rst = 1, start = 0, relu_en = 0, in_valid = 0;
  logic [11:0] base_addr = '0;
  logic [14:0] len = '0;
  logic [3:0] shift = '0;
  logic [15:0] in_data = '0;
  logic in_ready, we_a, we_b, busy, done;
  logic [11:0] addr_a, addr_b;
  logic [63:0] din_a, din_b;
  int checks = 0, errors = 0, cyc = 0;
  int done_cnt = 0, done_cyc = 0, wr_cnt = 0, last_wr_cyc = 0;
  int w0, d0, c0, start_cyc, acc_cyc;
  logic [75:0] wq[$];
  logic [75:0] ex[$];
  logic signed [15:0] vals[$];

  fmap_writeback dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len), .shift(shift),
    .relu_en(relu_en), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .addr_a(addr_a), .din_a(din_a), .we_a(we_a), .addr_b(addr_b), .din_b(din_b), .we_b(we_b),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (we_a) wq.push_back({addr_a, din_a});
    if (we_b) wq.push_back({addr_b, din_b});
    if (we_a || we_b) begin wr_cnt++; last_wr_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  function automatic logic [7:0] rq(logic signed [15:0] v, int sh, bit relu);
    int t;
    t = int'(v) >>> sh;
    if (relu && t < 0) t = 0;
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return t[7:0];
  endfunction

  // memory image as consecutive words from base, partial last word zero-padded
  function automatic void build_exp(int base, int sh, bit relu);
    int n = vals.size();
    ex.delete();
    for (int w = 0; w < (n + 7) / 8; w++) begin
      logic [63:0] d = '0;
      for (int b = 0; b < 8; b++) if (8 * w + b < n) d[8*b+:8] = rq(vals[8*w+b], sh, relu);
      ex.push_back({12'(base + w), d});
    end
  endfunction

  task automatic run_job(input int base, input int sh, input bit relu, input int gap, input bit busy_start);
    w0 = wq.size(); d0 = done_cnt; c0 = wr_cnt;
    @(posedge clk); #1;
    start = 1; base_addr = 12'(base); len = 15'(vals.size()); shift = 4'(sh); relu_en = relu;
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 0; base_addr = 12'($urandom); shift = 4'($urandom); relu_en = ~relu;
    foreach (vals[i]) begin
      while (gap > 0 && $urandom_range(99) < gap) begin
        in_valid = 0; in_data = 16'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1; in_data = vals[i];
      if (busy_start && i == 3) begin start = 1; len = 15'd1; base_addr = 12'h0; end
      @(posedge clk); #1;
      start = 0; acc_cyc = cyc;
    end
    in_valid = 0;
    for (int k = 0; k < 20 && done_cnt == d0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, we_a, we_b, busy, done, addr_a, addr_b, din_a, din_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {in_ready, we_a, we_b, busy, done, addr_a, addr_b, din_a, din_b});
    end
    rst = 0;
  endtask

  task automatic test_pair;
    vals.delete();
    for (int i = 0; i < 16; i++) vals.push_back(16'(i));
    build_exp(12'h010, 0, 0);
    run_job(12'h010, 0, 0, 0, 0);
    checks++;
    if (wq.size() - w0 != 2) begin errors++; $display("FAIL pair_count: got %0d required 2", wq.size() - w0); end
    else begin
      foreach (ex[i]) begin
        checks++;
        if (wq[w0+i] !== ex[i]) begin errors++; $display("FAIL pair_word%0d: got %h required %h", i, wq[w0+i], ex[i]); end
      end
      checks++;
      if (wq[w0] !== {12'h010, 64'h0706050403020100}) begin errors++; $display("FAIL pair_literal: got %h", wq[w0]); end
    end
    checks++;
    if (wr_cnt - c0 != 1) begin errors++; $display("FAIL pair_write_cycles: got %0d required 1", wr_cnt - c0); end
    checks++;
    if (last_wr_cyc != acc_cyc) begin errors++; $display("FAIL pair_write_time: got %0d required %0d", last_wr_cyc, acc_cyc); end
    checks++;
    if (done_cnt - d0 != 1 || done_cyc != acc_cyc + 1) begin
      errors++; $display("FAIL pair_done: got n=%0d at %0d required n=1 at %0d", done_cnt - d0, done_cyc, acc_cyc + 1);
    end
  endtask

  task automatic test_partial;
    vals = '{16'sd1, 16'sd2, 16'sd3};
    run_job(12'h123, 0, 0, 0, 0);
    checks++;
    if (wq.size() - w0 != 1 || wq[w0] !== {12'h123, 64'h0000000000030201}) begin
      errors++; $display("FAIL partial_write: got n=%0d %h required 1 %h", wq.size() - w0, wq[w0], {12'h123, 64'h30201});
    end
    checks++;
    if (done_cnt - d0 != 1 || done_cyc != acc_cyc + 1) begin errors++; $display("FAIL partial_done: got %0d at %0d", done_cnt - d0, done_cyc); end
  endtask

  task automatic test_saturation;
    for (int r = 0; r < 2; r++) begin
      logic [63:0] want;
      want = r ? 64'h7F : 64'hFF807F;
      vals = '{16'sh7FFF, -16'sh8000, -16'sd4};
      run_job(12'h200, 2, r[0], 0, 0);
      checks++;
      if (wq.size() - w0 != 1 || wq[w0] !== {12'h200, want}) begin
        errors++; $display("FAIL sat_relu%0d: got %h required %h", r, wq[w0], {12'h200, want});
      end
    end
  endtask

  task automatic test_wrap;
    vals.delete();
    for (int i = 0; i < 24; i++) vals.push_back(16'($urandom_range(0, 255) - 128));
    build_exp(12'hFFF, 0, 0);
    run_job(12'hFFF, 0, 0, 0, 0);
    checks++;
    if (wq.size() - w0 != 3) begin errors++; $display("FAIL wrap_count: got %0d required 3", wq.size() - w0); end
    else foreach (ex[i]) begin
      checks++;
      if (wq[w0+i] !== ex[i]) begin errors++; $display("FAIL wrap_word%0d: got %h required %h", i, wq[w0+i], ex[i]); end
    end
    checks++;
    if (wr_cnt - c0 != 2) begin errors++; $display("FAIL wrap_write_cycles: got %0d required 2", wr_cnt - c0); end
  endtask

  task automatic test_empty;
    vals.delete();
    run_job(12'h055, 0, 0, 0, 0);
    checks++;
    if (wq.size() != w0 || done_cnt - d0 != 1 || done_cyc != start_cyc) begin
      errors++; $display("FAIL empty_job: got writes=%0d dones=%0d at %0d required 0 1 at %0d", wq.size() - w0, done_cnt - d0, done_cyc, start_cyc);
    end
  endtask

  task automatic test_midjob_reset;
    w0 = wq.size();
    @(posedge clk); #1;
    start = 1; base_addr = 12'h010; len = 15'd16; shift = 0; relu_en = 0;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 10; i++) begin in_valid = 1; in_data = 16'(i + 40); @(posedge clk); #1; end
    in_valid = 0; rst = 1;
    #2;
    checks++;
    if ({in_ready, we_a, we_b, busy, done, addr_a, addr_b, din_a, din_b} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got %h required 0", {in_ready, we_a, we_b, busy, done, addr_a, addr_b, din_a, din_b});
    end
    repeat (2) @(posedge clk);
    #1; rst = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wq.size() != w0) begin errors++; $display("FAIL midreset_writes: got %0d required 0", wq.size() - w0); end
    vals.delete();
    for (int i = 0; i < 16; i++) vals.push_back(16'(i));
    run_job(12'h010, 0, 0, 0, 0);
    checks++;
    if (wq.size() - w0 != 2 || wq[w0] !== {12'h010, 64'h0706050403020100} || wq[w0+1] !== {12'h011, 64'h0F0E0D0C0B0A0908}) begin
      errors++; $display("FAIL midreset_rerun: got n=%0d %h %h", wq.size() - w0, wq[w0], wq[w0+1]);
    end
  endtask

  task automatic test_back_to_back;
    for (int j = 0; j < 4; j++) begin
      int base = $urandom_range(0, 4095), sh = $urandom_range(0, 15), n = $urandom_range(4, 45);
      bit relu = 1'($urandom);
      vals.delete();
      for (int i = 0; i < n; i++) vals.push_back(16'($urandom));
      build_exp(base, sh, relu);
      run_job(base, sh, relu, j == 0 ? 0 : 35, 1);
      checks++;
      if (wq.size() - w0 != ex.size()) begin errors++; $display("FAIL rand%0d_count: got %0d required %0d", j, wq.size() - w0, ex.size()); end
      else foreach (ex[i]) begin
        checks++;
        if (wq[w0+i] !== ex[i]) begin errors++; $display("FAIL rand%0d_word%0d: got %h required %h", j, i, wq[w0+i], ex[i]); end
      end
      checks++;
      if (wr_cnt - c0 != (ex.size() + 1) / 2 || done_cnt - d0 != 1 || done_cyc != acc_cyc + 1) begin
        errors++; $display("FAIL rand%0d_timing: got wr=%0d done=%0d at %0d required %0d 1 at %0d", j, wr_cnt - c0, done_cnt - d0, done_cyc, (ex.size() + 1) / 2, acc_cyc + 1);
      end
    end
    @(posedge clk); #1;
    start = 1; base_addr = 12'h0; len = 15'd2;
    @(posedge clk); #1;
    start = 0;
    checks++;
    if ({busy, in_ready} !== 2'b11) begin errors++; $display("FAIL run_flags: got %b required 11", {busy, in_ready}); end
    in_valid = 1; in_data = 16'd5;
    repeat (2) @(posedge clk);
    #1; in_valid = 0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_pair();
    test_partial();
    test_saturation();
    test_wrap();
    test_empty();
    test_midjob_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
